// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 44-bit binary to 13-digit packed BCD converter
//               (double-dabble, one bit per cycle). Optional overflow flag
//               enabled by defining BIN2BCD_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [43:0] bin,
    output logic        busy,
    output logic        done,
    output logic [51:0] bcd,
    output logic        ovf
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [5:0] LAST_CNT = 6'd43;

    logic [0:0]  state_q, state_d;
    logic [43:0] sreg_q,  sreg_d;
    logic [51:0] acc_q,   acc_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [51:0] bcd_q,   bcd_d;
    logic        done_q,  done_d;
    logic [50:0] w_adj;

    // Lower 12 digits get the full add-3 correction.
    genvar k;
    generate
        for (k = 0; k < 12; k++) begin : g_dab
            assign w_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3
                                                                 : acc_q[4*k +: 4];
        end
    endgenerate

    // Top digit: only its low three bits survive the shift; its bit 3 is the
    // decimal carry leaving the 13-digit window.
    assign w_adj[50:48] = acc_q[50:48] + ((acc_q[51:48] >= 4'd5) ? 3'd3 : 3'd0);

`ifdef BIN2BCD_SEQ_OVF_EN
    logic w_carry;
    logic flag_q, flag_d;
    logic ovf_q,  ovf_d;
    assign w_carry = (acc_q[51:48] >= 4'd5);
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef BIN2BCD_SEQ_OVF_EN
        flag_d  = flag_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sreg_d  = bin;
                    acc_d   = 52'd0;
                    cnt_d   = LAST_CNT;
`ifdef BIN2BCD_SEQ_OVF_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            SHIFT: begin
                acc_d  = {w_adj, sreg_q[43]};
                sreg_d = {sreg_q[42:0], 1'b0};
                cnt_d  = cnt_q - 6'd1;
`ifdef BIN2BCD_SEQ_OVF_EN
                flag_d = flag_q | w_carry;
`endif
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    bcd_d   = {w_adj, sreg_q[43]};
                    done_d  = 1'b1;
`ifdef BIN2BCD_SEQ_OVF_EN
                    ovf_d   = flag_q | w_carry;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= 44'd0;
            acc_q   <= 52'd0;
            cnt_q   <= 6'd0;
            bcd_q   <= 52'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

`ifdef BIN2BCD_SEQ_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Scoreboard bench for bin2bcd_seq; arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [43:0] bin;
    logic        busy;
    logic        done;
    logic [51:0] bcd;
    logic        ovf;

    typedef struct {
        logic [51:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam longint unsigned TEN13 = 64'd10_000_000_000_000;

    bin2bcd_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [43:0] b);
        exp_t            e;
        longint unsigned v;
        v     = longint'(b) % TEN13;
        e.bcd = 52'd0;
        for (int d = 0; d < 13; d++) begin
            e.bcd[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
`ifdef BIN2BCD_SEQ_OVF_EN
        e.ovf = (longint'(b) >= TEN13);
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 bcd=%0h expected no pending result", bcd);
            end else begin
                e = q.pop_front();
                chk("bcd", {12'd0, bcd}, {12'd0, e.bcd});
                chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
    end

    // Called at a negedge; waits for idle, issues one start, returns at the next negedge.
    task automatic issue(input logic [43:0] v);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        start = 1'b1;
        bin   = v;
        q.push_back(model(v));
        @(negedge clk);
        start = 1'b0;
        bin   = {12'(~v[43:32]), ~v[31:0]};
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int             n;
        logic [43:0]    v;
        logic [31:0]    r0;
        logic [31:0]    r1;
        longint unsigned lv;

        reset = 1'b1;
        start = 1'b0;
        bin   = 44'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_bcd",  {12'd0, bcd},  64'd0);
        chk("rst_ovf",  {63'd0, ovf},  64'd0);
        reset = 1'b0;

        // Zero operand: busy must last exactly 44 cycles, then done.
        issue(44'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd44);
        chk("done_after_busy", {63'd0, done}, 64'd1);

        issue(44'd1_234_567_890_123);
        issue(44'd9_999_999_999_999);
        issue(44'd10_000_000_000_000);
        issue(44'hFFFFFFFFFFF);
        issue(44'd1);
        issue(44'd10);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(44'd42);
        repeat (9) @(negedge clk);
        start = 1'b1;
        bin   = 44'd99;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_42");
        start = 1'b1;
        bin   = 44'd7;
        q.push_back(model(44'd7));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", {63'd0, busy}, 64'd1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", 64'(n), 64'd44);

        // Reset mid-conversion aborts without a done pulse.
        issue(44'd555);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_bcd",  {12'd0, bcd},  64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        issue(44'd555);
        wait_done("done_555");
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            r0 = $urandom;
            r1 = $urandom;
            lv = {20'd0, r1[11:0], r0};
            case ($urandom_range(0, 3))
                0:       v = lv[43:0];
                1:       v = 44'(lv % TEN13);
                2:       v = 44'(TEN13 - 64'd8 + 64'($urandom_range(0, 16)));
                default: v = 44'($urandom_range(0, 99999));
            endcase
            issue(v);
        end

        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drain", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
